opto_frame_sched: RTL
=====================

# opto_frame_sched

Ping-pong bank scheduler and uplink framer for the optical-encoder tooth-period packet RAM. The packet builder writes 160 bytes (40 teeth × 32-bit period, MSB first) into one bank of a 2×1024-byte RAM and pulses `make` when the packet is complete. This block swaps banks and streams the finished bank to the host uplink as a framed packet over a valid/ready byte interface. It sits between the packet builder/RAM and the UART/Ethernet TX mux.

## Interface

Parameters:
- `PKT_BYTES`, 160: data bytes per packet. Range 1..255.
- `HDR0`, 8'hA5: first sync byte.
- `HDR1`, 8'h5A: second sync byte.

Ports:
- `i_clk_50m`  in  1  system clock, 50 MHz.
- `i_rst`  in  1  reset. Asynchronous, active-high.
- `i_send_opto_flag`  in  1  host upload enable (level).
- `i_opto_make`  in  1  one-cycle pulse: packet complete in the write bank.
- `o_wr_bank`  out  1  bank the packet builder writes; it is the RAM write-address MSB.
- `o_rd_en`  out  1  RAM read strobe.
- `o_rd_addr`  out  11  `{rd_bank, 10-bit byte index}`.
- `i_rd_data`  in  8  RAM read data, valid exactly one cycle after `o_rd_en`.
- `o_tx_valid`  out  1  uplink byte valid.
- `o_tx_data`  out  8  uplink byte.
- `i_tx_ready`  in  1  uplink accepts the byte.
- `o_busy`  out  1  a frame is in progress (state ≠ IDLE).
- `o_overrun_cnt`  out  8  count of dropped packets; saturates at 255.

## Operation

- **Frame format:** HDR0, HDR1, LEN=`PKT_BYTES[7:0]`, SEQ, then bytes 0..PKT_BYTES-1 of the read bank, then CSUM.
  - CSUM = (SEQ + all data bytes) mod 256.
  - SEQ is an 8-bit counter. It increments by 1 after each completed frame and wraps from 255 to 0.
- **States:** IDLE, HDR0, HDR1, LEN, SEQ, RD, RDWAIT, DATA, CSUM.
  - IDLE → HDR0 when the make pulse is accepted.
  - HDR0 → HDR1 → LEN → SEQ → RD: each step advances on handshake.
  - RD: assert `o_rd_en` at index `idx`, then go to RDWAIT.
  - RDWAIT: capture `i_rd_data` into the TX register and add it to the checksum, then go to DATA.
  - DATA, on handshake: go to CSUM if `idx == PKT_BYTES-1`; otherwise increment `idx` and go to RD.
  - CSUM → IDLE on handshake, and SEQ increments.
- **Accepting `make`:**
  - `make` is accepted when `i_send_opto_flag`=1 and either:
    - state = IDLE, or
    - state = CSUM and the CSUM handshake completes in the same cycle. The block then goes directly to HDR0.
  - On accept: `rd_bank` ← `o_wr_bank`, `o_wr_bank` toggles, checksum clears, `idx` clears.
- **Refusing `make`:**
  - `make` with `i_send_opto_flag`=0 is ignored: no swap, no count.
  - `make` with the flag set while a frame is busy (not accepted per above) is dropped. There is no swap, so the builder overwrites the same bank, and `o_overrun_cnt` increments.
- Deasserting `i_send_opto_flag` mid-frame does not abort the frame.
- **Handshake:** a transfer occurs when `o_tx_valid && i_tx_ready` at a rising edge. `o_tx_data` is stable while valid is high and not yet accepted. Valid is high in HDR0, HDR1, LEN, SEQ, DATA and CSUM, and low otherwise.
- **Widths:** checksum is 8-bit, wrap-around add. `idx` is 8 bits and is zero-extended into address bits [9:0].

## Timing

- All registers update on the rising edge of `i_clk_50m`.
- **Reset values:**
  - `i_rst` asserted at any time, including mid-frame, forces state IDLE immediately (asynchronously).
  - Reset values: `o_wr_bank`=0, `rd_bank`=0, `o_rd_en`=0, `o_rd_addr`=0, `o_tx_valid`=0, `o_tx_data`=0, `o_busy`=0, `o_overrun_cnt`=0, SEQ=0.
- **Latency:** a `make` accepted at edge t gives `o_wr_bank` toggled and `o_tx_valid`=1 with data HDR0 after t.
- **Throughput:**
  - Header bytes and CSUM: 1 byte per cycle with ready held high.
  - Data bytes: 3 cycles each (RD, RDWAIT, DATA).
  - A full frame with ready held high takes 4 + 3·160 + 1 = 485 cycles. This is far shorter than a 40-tooth revolution.
- `o_rd_addr` is stable during RD and RDWAIT.

## Structure

- Shared package `opto_pkg` holds:
  - `OPTO_PKT_BYTES` = 160, `OPTO_HDR0`, `OPTO_HDR1`;
  - the state enumeration;
  - the RAM address width (11).
  The packet builder also uses these.
- No sub-module. The frame-byte mux and checksum are inline.

## Test plan

- **Basic frame:** preload bank 0 with byte[i]=i; flag=1; pulse make; hold ready=1.
  - Expect `o_wr_bank`=1.
  - Expect the frame A5 5A A0 00 00..9F B0.
  - Expect `o_busy` to fall after CSUM.
- **Ping-pong and SEQ:** run a second make with bank 1 filled with 8'hFF.
  - Expect reads from bank 1 (`o_rd_addr[10]`=1).
  - SEQ=01, CSUM = (1 + 160·255) mod 256 = 0x61.
  - `o_wr_bank` returns to 0.
- **Backpressure:** toggle ready pseudo-randomly.
  - Expect no byte lost or duplicated.
  - Expect data stable while valid && !ready.
  - Expect the same CSUM as the basic frame.
- **Overrun and boundaries:**
  - make during DATA → `o_overrun_cnt`=1, no bank toggle.
  - make coincident with the CSUM handshake → accepted, next edge is HDR0.
  - 300 dropped makes → count holds at 255.
- **Enable gating:** flag=0 with make → no frame, no toggle, count unchanged. Drop the flag mid-frame → the frame completes intact.
- **Reset mid-frame:** assert `i_rst` during DATA → all outputs at reset values asynchronously. After release, a make produces SEQ=00 from bank 0.

Source files
------------

// File: rtl/opto_frame_sched_pkg.sv
//==============================================================================
// Module  : opto_pkg
// Brief   : Shared constants and state encoding for the opto packet path.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package opto_pkg;

    localparam int         OPTO_PKT_BYTES = 160;
    localparam logic [7:0] OPTO_HDR0      = 8'hA5;
    localparam logic [7:0] OPTO_HDR1      = 8'h5A;
    localparam int         OPTO_RAM_AW    = 11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_HDR0   = 4'd1,
        ST_HDR1   = 4'd2,
        ST_LEN    = 4'd3,
        ST_SEQ    = 4'd4,
        ST_RD     = 4'd5,
        ST_RDWAIT = 4'd6,
        ST_DATA   = 4'd7,
        ST_CSUM   = 4'd8
    } opto_state_e;

    // Bank bit on top, byte index zero-extended into the 10-bit offset.
    function automatic logic [OPTO_RAM_AW-1:0] opto_rd_addr(input logic bank, input logic [7:0] idx);
        return {bank, 2'b00, idx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/opto_frame_sched_if.sv
//==============================================================================
// Module  : opto_frame_sched_if
// Brief   : Valid/ready byte uplink between the framer and the TX mux.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

interface opto_frame_sched_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/opto_frame_sched.sv
//==============================================================================
// Module  : opto_frame_sched
// Brief   : Ping-pong bank swap and framed uplink of tooth-period packets.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module opto_frame_sched
    import opto_pkg::*;
#(
    parameter int         PKT_BYTES = OPTO_PKT_BYTES,
    parameter logic [7:0] HDR0      = OPTO_HDR0,
    parameter logic [7:0] HDR1      = OPTO_HDR1
) (
    input  wire logic                   i_clk_50m,
    input  wire logic                   i_rst,
    input  wire logic                   i_send_opto_flag,
    input  wire logic                   i_opto_make,
    output logic                        o_wr_bank,
    output logic                        o_rd_en,
    output logic [OPTO_RAM_AW-1:0]      o_rd_addr,
    input  wire logic [7:0]             i_rd_data,
    opto_frame_sched_if.master          tx,
    output logic                        o_busy,
    output logic [7:0]                  o_overrun_cnt
);

    localparam logic [7:0] C_LEN      = 8'(PKT_BYTES);
    localparam logic [7:0] C_LAST_IDX = 8'(PKT_BYTES - 1);

    opto_state_e            state_q;
    logic                   wr_bank_q;
    logic                   rd_bank_q;
    logic                   rd_en_q;
    logic [OPTO_RAM_AW-1:0] rd_addr_q;
    logic                   valid_q;
    logic [7:0]             data_q;
    logic                   busy_q;
    logic [7:0]             idx_q;
    logic [7:0]             csum_q;
    logic [7:0]             seq_q;
    logic [7:0]             ovr_q;

    logic w_hs;
    logic w_accept;
    logic w_drop;

    assign w_hs     = valid_q && tx.ready;
    // A make may chain straight onto the closing CSUM transfer of the previous frame.
    assign w_accept = i_opto_make && i_send_opto_flag &&
                      ((state_q == ST_IDLE) || ((state_q == ST_CSUM) && w_hs));
    assign w_drop   = i_opto_make && i_send_opto_flag && !w_accept;

    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            busy_q    <= 1'b0;
            idx_q     <= 8'h00;
            csum_q    <= 8'h00;
            seq_q     <= 8'h00;
            ovr_q     <= 8'h00;
        end else begin
            rd_en_q <= 1'b0;

            if (w_drop && (ovr_q != 8'hFF)) begin
                ovr_q <= ovr_q + 8'd1;
            end

            if (w_accept) begin
                state_q   <= ST_HDR0;
                rd_bank_q <= wr_bank_q;
                wr_bank_q <= ~wr_bank_q;
                csum_q    <= 8'h00;
                idx_q     <= 8'h00;
                valid_q   <= 1'b1;
                data_q    <= HDR0;
                busy_q    <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                end
                ST_HDR0: if (w_hs) begin
                    state_q <= ST_HDR1;
                    data_q  <= HDR1;
                end
                ST_HDR1: if (w_hs) begin
                    state_q <= ST_LEN;
                    data_q  <= C_LEN;
                end
                ST_LEN: if (w_hs) begin
                    state_q <= ST_SEQ;
                    data_q  <= seq_q;
                end
                ST_SEQ: if (w_hs) begin
                    state_q   <= ST_RD;
                    valid_q   <= 1'b0;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= opto_rd_addr(rd_bank_q, idx_q);
                    csum_q    <= csum_q + seq_q;
                end
                ST_RD: begin
                    state_q <= ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    state_q <= ST_DATA;
                    data_q  <= i_rd_data;
                    csum_q  <= csum_q + i_rd_data;
                    valid_q <= 1'b1;
                end
                ST_DATA: if (w_hs) begin
                    if (idx_q == C_LAST_IDX) begin
                        state_q <= ST_CSUM;
                        data_q  <= csum_q;
                    end else begin
                        state_q   <= ST_RD;
                        valid_q   <= 1'b0;
                        rd_en_q   <= 1'b1;
                        idx_q     <= idx_q + 8'd1;
                        rd_addr_q <= opto_rd_addr(rd_bank_q, idx_q + 8'd1);
                    end
                end
                ST_CSUM: if (w_hs) begin
                    seq_q <= seq_q + 8'd1;
                    if (!w_accept) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_bank     = wr_bank_q;
    assign o_rd_en       = rd_en_q;
    assign o_rd_addr     = rd_addr_q;
    assign o_busy        = busy_q;
    assign o_overrun_cnt = ovr_q;
    assign tx.valid      = valid_q;
    assign tx.data       = data_q;

endmodule

`default_nettype wire
